// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// The hazard comparator and the forwarding logic share the register-address width.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W  = 3;
    localparam int STALL_CNT_W = 16;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
    } ctrl_en_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and enable/flush strobes back to its registers.
// The slave side is the sequencer. The master side is the pipeline or the bench.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic                   id_uses_rs2;
    logic                   ex_memread;
    logic [REG_ADDR_W-1:0]  ex_rd;
    logic                   branch_taken;
    logic                   dmem_busy;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   ifid_flush;
    logic                   idex_write;
    logic                   idex_bubble;
    logic                   exmem_write;
    logic [1:0]             ctrl_state;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // No valid/ready handshake: the hazard inputs are level signals sampled every cycle.
    // The strobes answer combinationally in the same cycle.
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, branch_taken, dmem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
        input  ctrl_state, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, branch_taken, dmem_busy,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
        output ctrl_state, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in EX and the sources in ID.
// It is kept standalone so that the forwarding unit can reuse it.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int R0_HARDWIRED = 1
) (
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  uses_rs2_i,
    input  logic                  memread_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  load_use_o
);

    logic rd_is_r0;
    logic src_match;

    assign rd_is_r0   = (R0_HARDWIRED != 0) && (rd_i == '0);
    assign src_match  = (rd_i == rs1_i) || (uses_rs2_i && (rd_i == rs2_i));
    assign load_use_o = memread_i && src_match && !rd_is_r0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. It handles load-use bubbles, taken-branch flushes
// and data-memory freezes. The priority order is dmem_busy, then branch_taken, then load_use.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int R0_HARDWIRED      = 1
) (
    input  logic               CLK,
    input  logic               Reset,
    pipe_hazard_ctrl_if.slave  hz
);

    ctrl_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use;
    ctrl_en_t               en;

    pipe_hazard_ctrl_hazard_detect #(.R0_HARDWIRED(R0_HARDWIRED)) u_hazard_detect (
        .rs1_i      (hz.id_rs1),
        .rs2_i      (hz.id_rs2),
        .uses_rs2_i (hz.id_uses_rs2),
        .memread_i  (hz.ex_memread),
        .rd_i       (hz.ex_rd),
        .load_use_o (load_use)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A frozen cycle holds both the state and the counter, so the sequence resumes where it stopped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!hz.dmem_busy) begin
            if (hz.branch_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                            state_d = ST_LOAD_STALL;
                            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                    ST_LOAD_STALL, ST_FLUSH: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (!en.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_comb begin
        en = '0;
        if (Reset || hz.dmem_busy) begin
            en = '0;
        end else if (hz.branch_taken || (state_q == ST_FLUSH)) begin
            en = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                   idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1};
        end else if ((state_q == ST_LOAD_STALL) || load_use) begin
            en = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                   idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1};
        end else begin
            en = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                   idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1};
        end
    end

    assign hz.pc_write    = en.pc_write;
    assign hz.ifid_write  = en.ifid_write;
    assign hz.ifid_flush  = en.ifid_flush;
    assign hz.idex_write  = en.idex_write;
    assign hz.idex_bubble = en.idex_bubble;
    assign hz.exmem_write = en.exmem_write;
    assign hz.ctrl_state  = state_q;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. One instance uses the default parameters.
// The other uses LOAD_STALL_CYCLES=2 and FLUSH_CYCLES=3. Both instances receive the same inputs.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    // Bit order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
    localparam logic [5:0] EN_RUN    = 6'b110101;
    localparam logic [5:0] EN_STALL  = 6'b000111;
    localparam logic [5:0] EN_FLUSH  = 6'b111111;
    localparam logic [5:0] EN_FROZEN = 6'b000000;

    logic CLK = 1'b0;
    logic Reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if if_def ();
    pipe_hazard_ctrl_if if_cfg ();

    pipe_hazard_ctrl u_def (
        .CLK   (CLK),
        .Reset (Reset),
        .hz    (if_def.slave)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .R0_HARDWIRED(1)) u_cfg (
        .CLK   (CLK),
        .Reset (Reset),
        .hz    (if_cfg.slave)
    );

    function automatic logic [5:0] en_def();
        return {if_def.pc_write, if_def.ifid_write, if_def.ifid_flush,
                if_def.idex_write, if_def.idex_bubble, if_def.exmem_write};
    endfunction

    function automatic logic [5:0] en_cfg();
        return {if_cfg.pc_write, if_cfg.ifid_write, if_cfg.ifid_flush,
                if_cfg.idex_write, if_cfg.idex_bubble, if_cfg.exmem_write};
    endfunction

    task automatic set_in(input logic [2:0] rs1, input logic [2:0] rs2, input logic uses,
                          input logic memread, input logic [2:0] rd, input logic br,
                          input logic busy);
        if_def.id_rs1 = rs1;  if_def.id_rs2 = rs2;  if_def.id_uses_rs2 = uses;
        if_def.ex_memread = memread;  if_def.ex_rd = rd;
        if_def.branch_taken = br;  if_def.dmem_busy = busy;
        if_cfg.id_rs1 = rs1;  if_cfg.id_rs2 = rs2;  if_cfg.id_uses_rs2 = uses;
        if_cfg.ex_memread = memread;  if_cfg.ex_rd = rd;
        if_cfg.branch_taken = br;  if_cfg.dmem_busy = busy;
    endtask

    task automatic idle();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle();
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        @(negedge CLK); #1;
        n_total++; if (en_def() !== EN_FROZEN) $display("FAIL reset_en_def got=%b exp=%b", en_def(), EN_FROZEN); else n_pass++;
        n_total++; if (en_cfg() !== EN_FROZEN) $display("FAIL reset_en_cfg got=%b exp=%b", en_cfg(), EN_FROZEN); else n_pass++;
        n_total++; if (if_cfg.ctrl_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", if_cfg.ctrl_state); else n_pass++;
        n_total++; if (if_cfg.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", if_cfg.stall_cnt); else n_pass++;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        n_total++; if (en_def() !== EN_RUN) $display("FAIL post_reset_run got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        #1;
        n_total++; if (en_def() !== EN_STALL) $display("FAIL lu_same_cycle got=%b exp=%b", en_def(), EN_STALL); else n_pass++;
        @(negedge CLK);
        idle();
        #1;
        n_total++; if (if_def.ctrl_state !== 2'd0) $display("FAIL lu_next_state got=%0d exp=0", if_def.ctrl_state); else n_pass++;
        n_total++; if (en_def() !== EN_RUN) $display("FAIL lu_next_en got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
        n_total++; if (if_def.stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", if_def.stall_cnt); else n_pass++;
    endtask

    task automatic test_reg_match();
        do_reset();
        set_in(3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        #1;
        n_total++; if (en_def() !== EN_RUN) $display("FAIL r0_no_stall got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
        @(negedge CLK);
        set_in(3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        #1;
        n_total++; if (en_def() !== EN_RUN) $display("FAIL rs2_unused got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
        @(negedge CLK);
        set_in(3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        #1;
        n_total++; if (en_def() !== EN_STALL) $display("FAIL rs2_used got=%b exp=%b", en_def(), EN_STALL); else n_pass++;
        @(negedge CLK);
        set_in(3'd2, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
        #1;
        n_total++; if (en_def() !== EN_RUN) $display("FAIL no_memread got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
    endtask

    task automatic test_flush();
        logic [1:0] exp_state [4];
        logic [5:0] exp_en    [4];
        exp_state = '{2'd0, 2'd2, 2'd2, 2'd0};
        exp_en    = '{EN_FLUSH, EN_FLUSH, EN_FLUSH, EN_RUN};
        do_reset();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (if_cfg.ctrl_state !== exp_state[i]) $display("FAIL flush_state[%0d] got=%0d exp=%0d", i, if_cfg.ctrl_state, exp_state[i]); else n_pass++;
            n_total++; if (en_cfg() !== exp_en[i]) $display("FAIL flush_en[%0d] got=%b exp=%b", i, en_cfg(), exp_en[i]); else n_pass++;
            if (i == 1) begin
                n_total++; if (en_def() !== EN_RUN) $display("FAIL flush1_def_en got=%b exp=%b", en_def(), EN_RUN); else n_pass++;
            end
            @(negedge CLK);
            idle();
        end
    endtask

    task automatic test_busy_stall();
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        #1;
        n_total++; if (en_cfg() !== EN_STALL) $display("FAIL busy_lu_en got=%b exp=%b", en_cfg(), EN_STALL); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
            #1;
            n_total++; if (en_cfg() !== EN_FROZEN) $display("FAIL busy_frozen_en[%0d] got=%b exp=%b", i, en_cfg(), EN_FROZEN); else n_pass++;
            n_total++; if (if_cfg.ctrl_state !== 2'd1) $display("FAIL busy_hold_state[%0d] got=%0d exp=1", i, if_cfg.ctrl_state); else n_pass++;
        end
        @(negedge CLK);
        idle();
        #1;
        n_total++; if (en_cfg() !== EN_STALL) $display("FAIL busy_resume_en got=%b exp=%b", en_cfg(), EN_STALL); else n_pass++;
        n_total++; if (if_cfg.ctrl_state !== 2'd1) $display("FAIL busy_resume_state got=%0d exp=1", if_cfg.ctrl_state); else n_pass++;
        @(negedge CLK); #1;
        n_total++; if (if_cfg.ctrl_state !== 2'd0) $display("FAIL busy_done_state got=%0d exp=0", if_cfg.ctrl_state); else n_pass++;
        n_total++; if (en_cfg() !== EN_RUN) $display("FAIL busy_done_en got=%b exp=%b", en_cfg(), EN_RUN); else n_pass++;
        n_total++; if (if_cfg.stall_cnt !== 16'd6) $display("FAIL busy_stall_cnt got=%0d exp=6", if_cfg.stall_cnt); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        #1;
        n_total++; if (en_cfg() !== EN_FLUSH) $display("FAIL prio_br_lu_cfg got=%b exp=%b", en_cfg(), EN_FLUSH); else n_pass++;
        n_total++; if (en_def() !== EN_FLUSH) $display("FAIL prio_br_lu_def got=%b exp=%b", en_def(), EN_FLUSH); else n_pass++;
        @(negedge CLK);
        idle();
        #1;
        n_total++; if (if_cfg.ctrl_state !== 2'd2) $display("FAIL prio_cfg_state got=%0d exp=2", if_cfg.ctrl_state); else n_pass++;
        n_total++; if (if_def.ctrl_state !== 2'd0) $display("FAIL prio_def_state got=%0d exp=0", if_def.ctrl_state); else n_pass++;
        n_total++; if (if_def.stall_cnt !== 16'd0) $display("FAIL prio_def_stall_cnt got=%0d exp=0", if_def.stall_cnt); else n_pass++;
        @(negedge CLK);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        #1;
        n_total++; if (en_cfg() !== EN_FROZEN) $display("FAIL prio_busy_over_br got=%b exp=%b", en_cfg(), EN_FROZEN); else n_pass++;
        n_total++; if (if_cfg.ctrl_state !== 2'd2) $display("FAIL prio_busy_state got=%0d exp=2", if_cfg.ctrl_state); else n_pass++;
        @(negedge CLK);
        idle();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        @(negedge CLK);
        idle();
        @(negedge CLK);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge CLK);
        idle();
        #1;
        n_total++; if (if_cfg.ctrl_state !== 2'd2) $display("FAIL rmf_in_flush got=%0d exp=2", if_cfg.ctrl_state); else n_pass++;
        n_total++; if (if_cfg.stall_cnt !== 16'd2) $display("FAIL rmf_pre_stall_cnt got=%0d exp=2", if_cfg.stall_cnt); else n_pass++;
        #1;
        Reset = 1'b1;
        #1;
        n_total++; if (if_cfg.ctrl_state !== 2'd0) $display("FAIL rmf_state got=%0d exp=0", if_cfg.ctrl_state); else n_pass++;
        n_total++; if (if_cfg.stall_cnt !== 16'd0) $display("FAIL rmf_stall_cnt got=%0d exp=0", if_cfg.stall_cnt); else n_pass++;
        n_total++; if (en_cfg() !== EN_FROZEN) $display("FAIL rmf_en got=%b exp=%b", en_cfg(), EN_FROZEN); else n_pass++;
        @(negedge CLK); #1;
        n_total++; if (en_cfg() !== EN_FROZEN) $display("FAIL rmf_en_held got=%b exp=%b", en_cfg(), EN_FROZEN); else n_pass++;
        Reset = 1'b0;
        #1;
        n_total++; if (en_cfg() !== EN_RUN) $display("FAIL rmf_release_en got=%b exp=%b", en_cfg(), EN_RUN); else n_pass++;
        n_total++; if (if_cfg.ctrl_state !== 2'd0) $display("FAIL rmf_release_state got=%0d exp=0", if_cfg.ctrl_state); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_reg_match();
        test_flush();
        test_busy_stall();
        test_priority();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 16-bit core.
- Generates write enables and bubble/flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers three conditions: load-use hazards, taken branches resolved in EX, and data-memory busy.
- Sits beside the pipeline registers and drives their enable inputs; idex_write drives the ID/EX RB_write input.

Parameters:
LOAD_STALL_CYCLES, 1, total bubbles inserted per load-use hazard (legal 1..15)
FLUSH_CYCLES, 1, total cycles IF/ID and ID/EX are flushed per taken branch (legal 1..15)
R0_HARDWIRED, 1, when 1, register 0 never creates a hazard

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
id_rs1  in  3  source register 1 of the instruction in ID
id_rs2  in  3  source register 2 of the instruction in ID
id_uses_rs2  in  1  instruction in ID reads rs2
ex_memread  in  1  instruction in EX is a load
ex_rd  in  3  destination register of the instruction in EX
branch_taken  in  1  branch in EX resolved taken
dmem_busy  in  1  data memory has not completed its access
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX enable
idex_bubble  out  1  zero the ID/EX control inputs (RegWrite, MemWrite, MemRead, RegStore)
exmem_write  out  1  EX/MEM enable
ctrl_state  out  2  0=RUN, 1=LOAD_STALL, 2=FLUSH
stall_cnt  out  16  saturating count of cycles with pc_write=0

Behaviour:
- Registered state: ctrl_state, a 4-bit down-counter cnt, stall_cnt. All other outputs are combinational from state and inputs.
- Reset asserted (asynchronous): ctrl_state=RUN, cnt=0, stall_cnt=0. While Reset is high, all enables=0 and ifid_flush=idex_bubble=0.
- load_use = ex_memread && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)) && !(R0_HARDWIRED && ex_rd==0).
- Priority, applied in every state: dmem_busy > branch_taken > load_use.
- dmem_busy=1 (any state): freeze.
  - All four enables=0; flush=bubble=0.
  - ctrl_state and cnt hold. An in-progress stall or flush resumes exactly where it stopped.
- RUN:
  - Normal (no event): all enables=1, flush=bubble=0.
  - branch_taken: pc_write=1 (target loads), ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_write=1.
    - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1.
  - load_use: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1.
    - If LOAD_STALL_CYCLES>1: go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
- LOAD_STALL:
  - Outputs as load_use in RUN; cnt decrements each non-frozen cycle.
  - Leave to RUN on the cycle cnt==1.
  - branch_taken here is handled as in RUN and overrides the stall; cnt is reloaded for FLUSH.
- FLUSH:
  - Outputs as the branch case in RUN, except pc_write=1 with the PC advancing sequentially.
  - cnt decrements; leave to RUN when cnt==1.
  - A new branch_taken reloads cnt=FLUSH_CYCLES-1.
- stall_cnt increments on every non-reset cycle with pc_write=0 and saturates at 0xFFFF.
- Latency: hazard outputs respond in the same cycle as their inputs; state changes take effect at the next CLK edge.
- Reset mid-stall or mid-flush: abandon immediately; the pipeline returns to RUN.

Decomposition:
- Shared package holds:
  - state encoding constants ST_RUN=0, ST_LOAD_STALL=1, ST_FLUSH=2;
  - REG_ADDR_W=3;
  - STALL_CNT_W=16.
- One natural sub-module: hazard_detect, the combinational load_use compare, reused later for forwarding checks.

Test Plan:
- ex_memread=1, ex_rd=3, id_rs1=3 in RUN, defaults -> same cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle ctrl_state=RUN, pc_write=1; stall_cnt=1.
- ex_memread=1, ex_rd=0, id_rs1=0, R0_HARDWIRED=1 -> no stall, all enables=1.
- branch_taken=1 with FLUSH_CYCLES=3 -> ifid_flush=idex_bubble=1 for 3 consecutive cycles; ctrl_state goes 0,2,2,0.
- LOAD_STALL_CYCLES=2: load-use hazard, then dmem_busy=1 for 4 cycles while in LOAD_STALL -> all enables=0 for 4 cycles, cnt holds at 1; one further stall cycle after busy drops; stall_cnt=6.
- branch_taken and load_use asserted together -> flush outputs only, pc_write=1, no LOAD_STALL entry.
- Reset pulsed asynchronously mid-FLUSH (between edges) -> ctrl_state=RUN and stall_cnt=0 immediately; enables=0 until Reset falls.
